// File: rtl/period_meter_pkg.sv
// period_meter_pkg: shared FSM state type and averaging depth for period_meter
package period_meter_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, LOST} state_t;
  localparam int AVG_DEPTH = 4;
  localparam int AVG_SHIFT = $clog2(AVG_DEPTH);
endpackage

// File: rtl/period_meter_if.sv
// period_meter_if: measured signal in, period/high-time results out
interface period_meter_if #(parameter int WIDTH = 16);
  logic i_Sig;
  logic [WIDTH-1:0] o_Period;
  logic [WIDTH-1:0] o_High;
  logic o_Valid;
  logic o_Timeout;
  modport master (output i_Sig, input o_Period, o_High, o_Valid, o_Timeout);
  modport slave (input i_Sig, output o_Period, o_High, o_Valid, o_Timeout);
endinterface

// File: rtl/period_meter_edge_sync.sv
// edge_sync: 2-flop synchronizer plus edge flop; registered rise/fall pulses and level
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise,
  output logic fall,
  output logic lvl
);
  logic [2:0] sh_q, sh_d;
  logic rise_q, rise_d, fall_q, fall_d, lvl_q, lvl_d;
  always_comb begin
    sh_d = {sh_q[1:0], sig};
    rise_d = sh_q[1] & ~sh_q[2];
    fall_d = ~sh_q[1] & sh_q[2];
    lvl_d = sh_q[1];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sh_q <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      lvl_q <= 1'b0;
    end else begin
      sh_q <= sh_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      lvl_q <= lvl_d;
    end
  assign rise = rise_q;
  assign fall = fall_q;
  assign lvl = lvl_q;
endmodule

// File: rtl/period_meter.sv
// period_meter: measures rise-to-rise period and high time of a slow async signal.
// Define PERIOD_METER_AVG_EN to report the mean of the last AVG_DEPTH periods.
module period_meter import period_meter_pkg::*; #(
  parameter int WIDTH = 16
) (
  input logic i_Clk_Real,
  input logic i_Rst,
  period_meter_if.slave bus
);
  localparam logic [WIDTH-1:0] SAT = ~WIDTH'(1);
  logic rise, fall, lvl, sat, take;
  state_t state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d, mp_q, mp_d, mh_q, mh_d;
  logic [WIDTH-1:0] per_q, per_d, hi_q, hi_d;
  logic mv_q, mv_d, vld_q, vld_d;
  edge_sync u_sync (.clk(i_Clk_Real), .rst(i_Rst), .sig(bus.i_Sig), .rise, .fall, .lvl);
  assign sat = cnt_q == SAT;
  assign take = state_q == ARMED && rise && !sat;
  // Any rise restarts counting; a rise in LOST or at saturation reports nothing.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hcnt_d = hcnt_q;
    if (rise) begin
      state_d = ARMED;
      cnt_d = WIDTH'(1);
      hcnt_d = WIDTH'(1);
    end else if (state_q == ARMED) begin
      cnt_d = cnt_q + WIDTH'(1);
      hcnt_d = hcnt_q + WIDTH'(lvl & ~fall);
      state_d = sat ? LOST : ARMED;
    end
  end
`ifdef PERIOD_METER_AVG_EN
  localparam int HW = WIDTH + AVG_SHIFT;
  localparam logic [AVG_SHIFT-1:0] FULL = AVG_SHIFT'(AVG_DEPTH - 1);
  logic [WIDTH-1:0] hp_q [AVG_DEPTH-1];
  logic [WIDTH-1:0] hp_d [AVG_DEPTH-1];
  logic [WIDTH-1:0] hh_q [AVG_DEPTH-1];
  logic [WIDTH-1:0] hh_d [AVG_DEPTH-1];
  logic [AVG_SHIFT-1:0] fill_q, fill_d;
  logic [HW-1:0] sp, sh;
  always_comb begin
    hp_d = hp_q;
    hh_d = hh_q;
    fill_d = fill_q;
    sp = HW'(cnt_q);
    sh = HW'(hcnt_q);
    for (int i = 0; i < AVG_DEPTH - 1; i++) begin
      sp = sp + HW'(hp_q[i]);
      sh = sh + HW'(hh_q[i]);
    end
    if (state_q == ARMED && sat) begin
      hp_d = '{default: '0};
      hh_d = '{default: '0};
      fill_d = '0;
    end else if (take) begin
      hp_d[0] = cnt_q;
      hh_d[0] = hcnt_q;
      for (int i = 1; i < AVG_DEPTH - 1; i++) begin
        hp_d[i] = hp_q[i-1];
        hh_d[i] = hh_q[i-1];
      end
      fill_d = fill_q == FULL ? fill_q : fill_q + AVG_SHIFT'(1);
    end
    mv_d = take && fill_q == FULL;
    mp_d = mv_d ? sp[HW-1:AVG_SHIFT] : mp_q;
    mh_d = mv_d ? sh[HW-1:AVG_SHIFT] : mh_q;
  end
  always_ff @(posedge i_Clk_Real or posedge i_Rst)
    if (i_Rst) begin
      hp_q <= '{default: '0};
      hh_q <= '{default: '0};
      fill_q <= '0;
    end else begin
      hp_q <= hp_d;
      hh_q <= hh_d;
      fill_q <= fill_d;
    end
`else
  always_comb begin
    mv_d = take;
    mp_d = take ? cnt_q : mp_q;
    mh_d = take ? hcnt_q : mh_q;
  end
`endif
  always_comb begin
    vld_d = mv_q;
    per_d = mv_q ? mp_q : per_q;
    hi_d = mv_q ? mh_q : hi_q;
  end
  always_ff @(posedge i_Clk_Real or posedge i_Rst)
    if (i_Rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      hcnt_q <= '0;
      mv_q <= 1'b0;
      mp_q <= '0;
      mh_q <= '0;
      vld_q <= 1'b0;
      per_q <= '0;
      hi_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hcnt_q <= hcnt_d;
      mv_q <= mv_d;
      mp_q <= mp_d;
      mh_q <= mh_d;
      vld_q <= vld_d;
      per_q <= per_d;
      hi_q <= hi_d;
    end
  assign bus.o_Period = per_q;
  assign bus.o_High = hi_q;
  assign bus.o_Valid = vld_q;
  assign bus.o_Timeout = state_q == LOST;
endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: random square-wave stimulus checked every cycle against a rise-time model
module tb_period_meter;
  localparam int W = 8;
  localparam int MAXV = 2**W - 1;
  typedef struct {int due; int p; int h;} ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  ev_t evq[$];
  int rises[$];
  int ap[$];
  int ah[$];
  int cyc = 0;
  int hi = 0;
  int n_chk = 0;
  int n_pass = 0;
  int exp_p = 0;
  int exp_h = 0;
  logic prev = 1'b0;
  always #5 clk = ~clk;
  period_meter_if #(.WIDTH(W)) bus ();
  period_meter #(.WIDTH(W)) dut (.i_Clk_Real(clk), .i_Rst(rst), .bus(bus));

  task automatic check(input string tag, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d want %0d at cycle %0d", tag, got, want, cyc);
  endtask

  // A completed period P (sampled rise to sampled rise) reports 4 cycles after the closing rise.
  task automatic push_period(input int p, input int h);
`ifdef PERIOD_METER_AVG_EN
    int sp, sh;
    ap.push_back(p);
    ah.push_back(h);
    if (ap.size() > 4) begin
      void'(ap.pop_front());
      void'(ah.pop_front());
    end
    if (ap.size() == 4) begin
      sp = 0;
      sh = 0;
      for (int i = 0; i < 4; i++) begin
        sp += ap[i];
        sh += ah[i];
      end
      evq.push_back('{cyc + 4, sp / 4, sh / 4});
    end
`else
    evq.push_back('{cyc + 4, p, h});
`endif
  endtask

  initial begin
    int p;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        rises.delete();
        ap.delete();
        ah.delete();
        prev = 1'b0;
        hi = 0;
      end else begin
        if (bus.i_Sig && !prev) begin
          if (rises.size() > 0) begin
            p = cyc - rises[rises.size()-1];
            if (p <= MAXV - 2) push_period(p, hi);
            else begin
              ap.delete();
              ah.delete();
            end
          end
          rises.push_back(cyc);
          if (rises.size() > 4) void'(rises.pop_front());
          hi = 0;
        end
        if (bus.i_Sig && rises.size() > 0) hi++;
        prev = bus.i_Sig;
      end
    end
  end

  initial begin
    logic v, tmo, found;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        evq.delete();
        exp_p = 0;
        exp_h = 0;
        check("rst_valid", int'(bus.o_Valid), 0);
        check("rst_period", int'(bus.o_Period), 0);
        check("rst_high", int'(bus.o_High), 0);
        check("rst_timeout", int'(bus.o_Timeout), 0);
      end else begin
        v = evq.size() > 0 && evq[0].due == cyc;
        if (v) begin
          exp_p = evq[0].p;
          exp_h = evq[0].h;
          void'(evq.pop_front());
        end
        tmo = 1'b0;
        found = 1'b0;
        for (int i = rises.size() - 1; i >= 0; i--)
          if (!found && rises[i] + 3 <= cyc) begin
            found = 1'b1;
            tmo = cyc - rises[i] - 3 >= MAXV - 1;
          end
        check("valid", int'(bus.o_Valid), int'(v));
        check("period", int'(bus.o_Period), exp_p);
        check("high", int'(bus.o_High), exp_h);
        check("timeout", int'(bus.o_Timeout), int'(tmo));
      end
    end
  end

  task automatic seg(input int h, input int l);
    bus.i_Sig = 1'b1;
    repeat (h) @(negedge clk);
    bus.i_Sig = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    bus.i_Sig = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    repeat (8) seg(2, 2);
    repeat (5) seg(25, 25);
    bus.i_Sig = 1'b1;
    repeat (25) @(negedge clk);
    bus.i_Sig = 1'b0;
    repeat (5) @(negedge clk);
    pulse_rst();
    repeat (4) seg(25, 25);
    repeat (30) seg(int'($urandom_range(1, 30)), int'($urandom_range(1, 30)));
    pulse_rst();
    repeat (2) seg(5, 5);
    repeat (2) seg(10, 10);
    repeat (3) seg(5, 5);
    repeat (20) seg(19 + int'($urandom_range(0, 2)), 19 + int'($urandom_range(0, 2)));
    seg(300, 10);
    repeat (3) seg(6, 6);
    seg(100, 153);
    seg(100, 154);
    seg(100, 155);
    repeat (6) seg(4, 4);
    repeat (12) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
